mem_wb_stage: RTL

- Pipeline register between the MEM stage and the register-file write port of the MIPS core.
- Captures the ALU result, load data, link address and destination register from MEM.
- Selects the write-back value and presents a one-cycle-late write request to the register file.
- Tracks the HALT instruction for the debug unit, with an optional retired-instruction counter.

---
 rtl/mem_wb_stage.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
//------------------------------------------------------------------------------
// Module   : mem_wb_stage
// Purpose  : MEM->WB pipeline register; selects write-back data, issues the
//            register-file write, tracks HALT. Optional macro
//            MEMWB_RETIRE_CNT_EN adds a retired-instruction counter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_wb_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int RETIRE_WIDTH   = 32
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_enable,
    input  logic                      i_flush,
    input  logic                      i_valid,
    input  logic [DATA_WIDTH-1:0]     i_aluresult,
    input  logic [DATA_WIDTH-1:0]     i_dataread,
    input  logic [DATA_WIDTH-1:0]     i_pcplus,
    input  logic [REG_ADDR_WIDTH-1:0] i_rd,
    input  logic                      i_regwrite,
    input  logic                      i_memtoreg,
    input  logic                      i_link,
    input  logic                      i_halt,
    output logic                      o_valid,
    output logic                      o_regwrite,
    output logic [REG_ADDR_WIDTH-1:0] o_rd,
    output logic [DATA_WIDTH-1:0]     o_writedata,
    output logic                      o_halted,
    output logic [RETIRE_WIDTH-1:0]   o_retired
);

    logic                      r_valid;
    logic                      r_regwrite;
    logic [REG_ADDR_WIDTH-1:0] r_rd;
    logic [DATA_WIDTH-1:0]     r_writedata;
    logic                      r_halted;

    logic                      w_capture;
    logic                      w_halt_in;
    logic [DATA_WIDTH-1:0]     w_wbdata;
    logic                      w_valid_nxt;
    logic                      w_regwrite_nxt;
    logic [REG_ADDR_WIDTH-1:0] w_rd_nxt;
    logic [DATA_WIDTH-1:0]     w_writedata_nxt;
    logic                      w_halted_nxt;

    assign w_capture = ~r_halted & i_enable & ~i_flush;
    assign w_halt_in = i_valid & i_halt;

    // Link takes precedence over memtoreg when both are asserted.
    assign w_wbdata = i_link     ? i_pcplus   :
                      i_memtoreg ? i_dataread : i_aluresult;

    always_comb begin
        w_valid_nxt     = r_valid;
        w_regwrite_nxt  = r_regwrite;
        w_rd_nxt        = r_rd;
        w_writedata_nxt = r_writedata;
        w_halted_nxt    = r_halted;
        if (r_halted) begin
            // Frozen: keep everything, but never re-issue a write.
            w_regwrite_nxt = 1'b0;
        end else if (i_enable) begin
            if (i_flush) begin
                w_valid_nxt     = 1'b0;
                w_regwrite_nxt  = 1'b0;
                w_rd_nxt        = '0;
                w_writedata_nxt = '0;
            end else begin
                w_valid_nxt     = i_valid;
                w_rd_nxt        = i_rd;
                w_writedata_nxt = w_wbdata;
                w_regwrite_nxt  = i_valid & i_regwrite & (i_rd != '0) & ~w_halt_in;
                if (w_halt_in) begin
                    w_halted_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_valid     <= 1'b0;
            r_regwrite  <= 1'b0;
            r_rd        <= '0;
            r_writedata <= '0;
            r_halted    <= 1'b0;
        end else begin
            r_valid     <= w_valid_nxt;
            r_regwrite  <= w_regwrite_nxt;
            r_rd        <= w_rd_nxt;
            r_writedata <= w_writedata_nxt;
            r_halted    <= w_halted_nxt;
        end
    end

`ifdef MEMWB_RETIRE_CNT_EN
    logic [RETIRE_WIDTH-1:0] r_retired;

    // Counts every valid instruction that enters WB, HALT included.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_retired <= '0;
        end else if (w_capture && i_valid) begin
            r_retired <= r_retired + RETIRE_WIDTH'(1);
        end
    end

    assign o_retired = r_retired;
`else
    logic w_unused;
    assign w_unused  = w_capture;
    assign o_retired = '0;
`endif

    assign o_valid     = r_valid;
    assign o_regwrite  = r_regwrite;
    assign o_rd        = r_rd;
    assign o_writedata = r_writedata;
    assign o_halted    = r_halted;

endmodule

`default_nettype wire
